// File: rtl/tex_lmem_responder.sv
// Banked local-memory responder for the texture unit's per-lane dcache port.
// Grants lanes per bank with same-address merging, writes in place, and returns grouped read responses.
module tex_lmem_responder #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int SIZE      = 1024,
  parameter int TAG_WIDTH = 8,
  parameter int RSPQ_SIZE = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQS-1:0]           req_valid_i,
  input  logic [NUM_REQS-1:0]           req_rw_i,
  input  logic [NUM_REQS*4-1:0]         req_byteen_i,
  input  logic [NUM_REQS*30-1:0]        req_addr_i,
  input  logic [NUM_REQS*32-1:0]        req_data_i,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag_i,
  output logic [NUM_REQS-1:0]           req_ready_o,
  output logic                          rsp_valid_o,
  output logic [NUM_REQS-1:0]           rsp_tmask_o,
  output logic [NUM_REQS*32-1:0]        rsp_data_o,
  output logic [TAG_WIDTH-1:0]          rsp_tag_o,
  input  logic                          rsp_ready_i
);
  localparam int IDX_W  = $clog2(SIZE);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PTR_W  = (RSPQ_SIZE > 1) ? $clog2(RSPQ_SIZE) : 1;
  localparam int CNT_W  = $clog2(RSPQ_SIZE + 1);

  logic [29:0]           lane_addr [NUM_REQS];
  logic [IDX_W-1:0]      lane_idx  [NUM_REQS];
  logic [TAG_WIDTH-1:0]  lane_tag  [NUM_REQS];
  logic                  leader_rw;
  logic [TAG_WIDTH-1:0]  leader_tag;
  logic [NUM_REQS-1:0]   eligible;
  logic [NUM_REQS-1:0]   grant;
  logic                  credit;

  logic [31:0]           mem_q [SIZE];

  logic                  stage_valid_q, stage_valid_d;
  logic [NUM_REQS-1:0]   stage_tmask_q, stage_tmask_d;
  logic [TAG_WIDTH-1:0]  stage_tag_q, stage_tag_d;
  logic [NUM_REQS*32-1:0] stage_data_q, stage_data_d;

  logic [NUM_REQS-1:0]   fifo_tmask_q [RSPQ_SIZE];
  logic [TAG_WIDTH-1:0]  fifo_tag_q   [RSPQ_SIZE];
  logic [NUM_REQS*32-1:0] fifo_data_q [RSPQ_SIZE];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  function automatic logic same_bank(input logic [29:0] a, input logic [29:0] b);
    if (NUM_BANKS == 1) return 1'b1;
    return a[BANK_W-1:0] == b[BANK_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSPQ_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    leader_rw  = 1'b0;
    leader_tag = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      lane_addr[i] = req_addr_i[i*30 +: 30];
      lane_idx[i]  = lane_addr[i][IDX_W-1:0];
      lane_tag[i]  = req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
    end
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        leader_rw  = req_rw_i[i];
        leader_tag = lane_tag[i];
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_i[i] && (req_rw_i[i] == leader_rw) && (lane_tag[i] == leader_tag);
    end
  end

  // A stage slot is always reserved, so the credit counts both the FIFO and the stage.
  assign credit = ({1'b0, count_q} + (CNT_W+1)'(stage_valid_q)) < (CNT_W+1)'(RSPQ_SIZE);

  // The first eligible lane on a bank wins it; later lanes ride along only on an identical address.
  always_comb begin
    logic winner_seen;
    logic conflict;
    grant = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      winner_seen = 1'b0;
      conflict    = 1'b0;
      for (int j = 0; j < NUM_REQS; j++) begin
        if ((j < i) && eligible[j] && !winner_seen && same_bank(lane_addr[j], lane_addr[i])) begin
          winner_seen = 1'b1;
          conflict    = (lane_addr[j] != lane_addr[i]);
        end
      end
      grant[i] = eligible[i] && !conflict && (leader_rw || credit) && !reset_i;
    end
  end

  assign req_ready_o = grant;

  // Later lanes overwrite earlier ones, so the highest merged lane wins each byte.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i] && req_rw_i[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (req_byteen_i[i*4 + b]) begin
            mem_q[lane_idx[i]][b*8 +: 8] <= req_data_i[i*32 + b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    stage_valid_d = 1'b0;
    stage_tmask_d = '0;
    stage_tag_d   = stage_tag_q;
    stage_data_d  = '0;
    if ((|grant) && !leader_rw) begin
      stage_valid_d = 1'b1;
      stage_tmask_d = grant;
      stage_tag_d   = leader_tag;
      for (int i = 0; i < NUM_REQS; i++) begin
        stage_data_d[i*32 +: 32] = grant[i] ? mem_q[lane_idx[i]] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stage_valid_q <= 1'b0;
    else         stage_valid_q <= stage_valid_d;
    stage_tmask_q <= stage_tmask_d;
    stage_tag_q   <= stage_tag_d;
    stage_data_q  <= stage_data_d;
  end

  assign push = stage_valid_q;
  assign pop  = rsp_valid_o && rsp_ready_i;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      fifo_tmask_q[wr_ptr_q] <= stage_tmask_q;
      fifo_tag_q[wr_ptr_q]   <= stage_tag_q;
      fifo_data_q[wr_ptr_q]  <= stage_data_q;
    end
  end

  assign rsp_valid_o = (count_q != '0) && !reset_i;
  assign rsp_tmask_o = fifo_tmask_q[rd_ptr_q];
  assign rsp_tag_o   = fifo_tag_q[rd_ptr_q];
  assign rsp_data_o  = fifo_data_q[rd_ptr_q];

endmodule

// File: tb/tb_tex_lmem_responder.sv
// Self-checking bench for tex_lmem_responder: directed lane requests feed a scoreboard queue,
// and a negedge monitor pops and compares every accepted response.
module tb_tex_lmem_responder;

   logic clk = 1'b0;
   logic reset;
   logic [3:0] reqValid;
   logic [3:0] reqRw;
   logic [3:0][3:0] reqByteen;
   logic [3:0][29:0] reqAddr;
   logic [3:0][31:0] reqData;
   logic [3:0][7:0] reqTag;
   logic [3:0] reqReady;
   logic rspValid;
   logic [3:0] rspTmask;
   logic [3:0][31:0] rspData;
   logic [7:0] rspTag;
   logic rspReady;

   typedef struct packed {
      logic [3:0] tmask;
      logic [7:0] tag;
      logic [3:0][31:0] data;
   } rsp_t;

   rsp_t expQ[$];
   int checks = 0;
   int failures = 0;
   logic [31:0] word [9];

   always #5 clk = ~clk;

   tex_lmem_responder dut (
      .clk_i(clk),
      .reset_i(reset),
      .req_valid_i(reqValid),
      .req_rw_i(reqRw),
      .req_byteen_i(reqByteen),
      .req_addr_i(reqAddr),
      .req_data_i(reqData),
      .req_tag_i(reqTag),
      .req_ready_o(reqReady),
      .rsp_valid_o(rspValid),
      .rsp_tmask_o(rspTmask),
      .rsp_data_o(rspData),
      .rsp_tag_o(rspTag),
      .rsp_ready_i(rspReady)
   );

   // Record one comparison and report it when the DUT disagrees with the bench's expectation.
   task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Drive one lane's request; it stays asserted until cleared.
   task automatic applyStimulus(input int lane, input logic rw, input logic [3:0] be,
                                input logic [29:0] addr, input logic [31:0] data, input logic [7:0] tag);
      reqValid[lane]  = 1'b1;
      reqRw[lane]     = rw;
      reqByteen[lane] = be;
      reqAddr[lane]   = addr;
      reqData[lane]   = data;
      reqTag[lane]    = tag;
   endtask

   task automatic clearLanes();
      reqValid = '0;
      reqRw = '0;
      reqByteen = '0;
      reqAddr = '0;
      reqData = '0;
      reqTag = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkReady(input string name, input logic [3:0] expected);
      @(negedge clk);
      checkOutput(name, 160'(reqReady), 160'(expected));
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (expQ.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      checkOutput(name, 160'(expQ.size()), 160'd0);
   endtask

   function automatic rsp_t mkRsp(input logic [3:0] m, input logic [7:0] t,
                                  input logic [31:0] d3, input logic [31:0] d2,
                                  input logic [31:0] d1, input logic [31:0] d0);
      rsp_t r;
      r.tmask = m;
      r.tag = t;
      r.data = {d3, d2, d1, d0};
      return r;
   endfunction

   // Every accepted response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      rsp_t e;
      if (!reset && rspValid && rspReady) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_rsp actual=%0h expected=none", {rspTmask, rspTag, rspData});
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp", 160'({rspTmask, rspTag, rspData}), 160'(e));
         end
      end
   end

   // Directed sequence: reset, fill, latency, bank conflict, merge, backpressure, byte enables, mix, reset drop.
   initial begin
      for (int i = 0; i < 4; i++) word[i] = 32'hA0A0_0000 | 32'(i);
      for (int i = 4; i < 7; i++) word[i] = 32'hC0DE_0000 | 32'(i);
      word[7] = 32'h1122_3344;
      word[8] = 32'hC0DE_0008;

      reset = 1'b1;
      rspReady = 1'b1;
      clearLanes();
      applyStimulus(0, 1'b1, 4'hF, 30'd0, 32'hFFFF_FFFF, 8'h00);
      @(negedge clk);
      checkOutput("reset_ready", 160'(reqReady), 160'd0);
      checkOutput("reset_rsp_valid", 160'(rspValid), 160'd0);
      tick();
      tick();
      reset = 1'b0;
      clearLanes();

      for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 4'hF, 30'(i), word[i], 8'h00);
      checkReady("fill_ready", 4'b1111);
      tick();
      clearLanes();
      for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 4'hF, 30'(4 + i), word[4 + i], 8'h00);
      checkReady("fill2_ready", 4'b1111);
      tick();
      clearLanes();
      applyStimulus(0, 1'b1, 4'hF, 30'd8, word[8], 8'h00);
      checkReady("fill3_ready", 4'b0001);
      tick();
      clearLanes();

      for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 4'h0, 30'(i), 32'h0, 8'h12);
      checkReady("read_ready", 4'b1111);
      expQ.push_back(mkRsp(4'b1111, 8'h12, word[3], word[2], word[1], word[0]));
      tick();
      clearLanes();
      @(negedge clk);
      checkOutput("latency_n1", 160'(rspValid), 160'd0);
      tick();
      @(negedge clk);
      checkOutput("latency_n2", 160'(rspValid), 160'd1);
      tick();

      applyStimulus(0, 1'b0, 4'h0, 30'd0, 32'h0, 8'h20);
      applyStimulus(1, 1'b0, 4'h0, 30'd4, 32'h0, 8'h20);
      applyStimulus(2, 1'b0, 4'h0, 30'd8, 32'h0, 8'h20);
      applyStimulus(3, 1'b0, 4'h0, 30'd1, 32'h0, 8'h20);
      checkReady("bank_c1", 4'b1001);
      expQ.push_back(mkRsp(4'b1001, 8'h20, word[1], 32'h0, 32'h0, word[0]));
      tick();
      reqValid[0] = 1'b0;
      reqValid[3] = 1'b0;
      checkReady("bank_c2", 4'b0010);
      expQ.push_back(mkRsp(4'b0010, 8'h20, 32'h0, 32'h0, word[4], 32'h0));
      tick();
      reqValid[1] = 1'b0;
      checkReady("bank_c3", 4'b0100);
      expQ.push_back(mkRsp(4'b0100, 8'h20, 32'h0, word[8], 32'h0, 32'h0));
      tick();
      clearLanes();

      for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 4'h0, 30'd5, 32'h0, 8'h33);
      checkReady("merge_ready", 4'b1111);
      expQ.push_back(mkRsp(4'b1111, 8'h33, word[5], word[5], word[5], word[5]));
      tick();
      clearLanes();
      waitDrain("drain_merge");

      rspReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1'b0, 4'h0, 30'(k), 32'h0, 8'h40 + 8'(k));
         checkReady($sformatf("bp_grant%0d", k), 4'b0001);
         expQ.push_back(mkRsp(4'b0001, 8'h40 + 8'(k), 32'h0, 32'h0, 32'h0, word[k]));
         tick();
      end
      applyStimulus(0, 1'b0, 4'h0, 30'd4, 32'h0, 8'h44);
      checkReady("bp_block0", 4'b0000);
      checkOutput("bp_head0", 160'({rspValid, rspTag, rspData[0]}), 160'({1'b1, 8'h40, word[0]}));
      tick();
      checkReady("bp_block1", 4'b0000);
      checkOutput("bp_head1", 160'({rspValid, rspTag, rspData[0]}), 160'({1'b1, 8'h40, word[0]}));
      tick();
      rspReady = 1'b1;
      checkReady("bp_block2", 4'b0000);
      tick();
      checkReady("bp_grant4", 4'b0001);
      expQ.push_back(mkRsp(4'b0001, 8'h44, 32'h0, 32'h0, 32'h0, word[4]));
      tick();
      clearLanes();
      waitDrain("drain_bp");

      applyStimulus(0, 1'b1, 4'b0011, 30'd7, 32'hAAAA_AAAA, 8'h00);
      applyStimulus(2, 1'b1, 4'b0110, 30'd7, 32'hBBBB_BBBB, 8'h00);
      checkReady("be_ready", 4'b0101);
      tick();
      clearLanes();
      applyStimulus(0, 1'b0, 4'h0, 30'd7, 32'h0, 8'h55);
      applyStimulus(1, 1'b0, 4'h0, 30'd5, 32'h0, 8'h55);
      checkReady("be_read_ready", 4'b0011);
      expQ.push_back(mkRsp(4'b0011, 8'h55, 32'h0, 32'h0, word[5], 32'h11BB_BBAA));
      tick();
      clearLanes();

      applyStimulus(0, 1'b0, 4'h0, 30'd0, 32'h0, 8'h01);
      applyStimulus(1, 1'b0, 4'h0, 30'd1, 32'h0, 8'h02);
      applyStimulus(2, 1'b1, 4'hF, 30'd2, 32'hDEAD_BEEF, 8'h01);
      checkReady("mix_ready", 4'b0001);
      expQ.push_back(mkRsp(4'b0001, 8'h01, 32'h0, 32'h0, 32'h0, word[0]));
      tick();
      clearLanes();
      waitDrain("drain_mix");

      rspReady = 1'b0;
      applyStimulus(0, 1'b0, 4'h0, 30'd1, 32'h0, 8'h60);
      checkReady("rq_grant0", 4'b0001);
      tick();
      reqTag[0] = 8'h61;
      reqAddr[0] = 30'd3;
      checkReady("rq_grant1", 4'b0001);
      tick();
      clearLanes();
      tick();
      @(negedge clk);
      checkOutput("rq_queued", 160'(rspValid), 160'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_drop_valid", 160'(rspValid), 160'd0);
      tick();
      rspReady = 1'b1;
      applyStimulus(0, 1'b0, 4'h0, 30'd7, 32'h0, 8'h70);
      applyStimulus(1, 1'b0, 4'h0, 30'd2, 32'h0, 8'h70);
      checkReady("post_rst_ready", 4'b0011);
      expQ.push_back(mkRsp(4'b0011, 8'h70, 32'h0, 32'h0, word[2], 32'h11BB_BBAA));
      tick();
      clearLanes();
      waitDrain("drain_final");
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
